// File: rtl/indexed_lsh_buf_if.sv
// Bundle of load, remove and output channels for indexed_lsh_buf, plus the array/status view.
// Every channel is valid/ready: a transfer happens on a rising edge where both are high, and the
// sender holds its payload stable while valid is high and ready is low.
interface indexed_lsh_buf_if #(
    parameter int data_width_param   = 32,
    parameter int max_elements_param = 16,
    parameter int idx_width_param    = 4
);
    localparam int arr_width   = data_width_param * max_elements_param;
    localparam int count_width = idx_width_param + 1;

    logic                       load_valid;
    logic [arr_width-1:0]       load_arr;
    logic [count_width-1:0]     load_count;
    logic                       load_ready;
    logic                       rem_valid;
    logic [idx_width_param-1:0] rem_idx;
    logic                       rem_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [data_width_param-1:0] out_value;
    logic [idx_width_param-1:0] out_idx;
    logic [arr_width-1:0]       arr_out;
    logic [count_width-1:0]     count;
    logic                       empty;
    logic                       full;
    logic                       rem_err;

    modport master (
        output load_valid, load_arr, load_count, rem_valid, rem_idx, out_ready,
        input  load_ready, rem_ready, out_valid, out_value, out_idx,
               arr_out, count, empty, full, rem_err
    );

    modport slave (
        input  load_valid, load_arr, load_count, rem_valid, rem_idx, out_ready,
        output load_ready, rem_ready, out_valid, out_value, out_idx,
               arr_out, count, empty, full, rem_err
    );
endinterface

// File: rtl/indexed_lsh_buf.sv
// Element array with whole-array load and indexed removal that closes the gap by shifting
// higher slots down one place; the removed element is presented on a one-deep output register.
module indexed_lsh_buf #(
    parameter int data_width_param   = 32,
    parameter int max_elements_param = 16,
    parameter int idx_width_param    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    indexed_lsh_buf_if.slave    bus,
    output logic [1:0]          fsm_state
);
    localparam int W  = data_width_param;
    localparam int N  = max_elements_param;
    localparam int IW = idx_width_param;
    localparam int CW = idx_width_param + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    mem   [N];
    logic [W-1:0]    mem_n [N];
    logic [CW-1:0]   cnt, cnt_n;
    logic            ov, ov_n;
    logic [W-1:0]    val, val_n;
    logic [IW-1:0]   oidx, oidx_n;
    logic            err, err_n;
    logic            empty_r, full_r;
    logic            load_fire, rem_fire, rem_ok;
    logic [N*W-1:0]  arr_pack;

    assign bus.load_ready = !ov || bus.out_ready;
    assign bus.rem_ready  = !empty_r && !bus.load_valid && (!ov || bus.out_ready);
    assign load_fire      = bus.load_valid && bus.load_ready;
    assign rem_fire       = bus.rem_valid && bus.rem_ready;
    assign rem_ok         = {1'b0, bus.rem_idx} < cnt;

    // Slots at or above count are always zero, so shifting every slot from k upward is enough
    // to move the tail down and leave a zero in the old last position.
    always_comb begin
        mem_n  = mem;
        cnt_n  = cnt;
        ov_n   = ov && !bus.out_ready;
        val_n  = val;
        oidx_n = oidx;
        err_n  = 1'b0;
        if (load_fire) begin
            cnt_n = (bus.load_count > CW'(N)) ? CW'(N) : bus.load_count;
            for (int i = 0; i < N; i++) begin
                mem_n[i] = (CW'(i) < cnt_n) ? bus.load_arr[(N-1-i)*W +: W] : '0;
            end
        end else if (rem_fire) begin
            if (rem_ok) begin
                for (int i = 0; i < N - 1; i++) begin
                    if (i >= int'(bus.rem_idx)) mem_n[i] = mem[i+1];
                end
                mem_n[N-1] = '0;
                cnt_n      = cnt - 1'b1;
                ov_n       = 1'b1;
                val_n      = mem[bus.rem_idx];
                oidx_n     = bus.rem_idx;
            end else begin
                err_n = 1'b1;
            end
        end
        if (ov_n)              state_n = STALL;
        else if (cnt_n != '0)  state_n = ACTIVE;
        else                   state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
            cnt     <= '0;
            ov      <= 1'b0;
            val     <= '0;
            oidx    <= '0;
            err     <= 1'b0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            state   <= IDLE;
        end else begin
            for (int i = 0; i < N; i++) mem[i] <= mem_n[i];
            cnt     <= cnt_n;
            ov      <= ov_n;
            val     <= val_n;
            oidx    <= oidx_n;
            err     <= err_n;
            empty_r <= (cnt_n == '0);
            full_r  <= (cnt_n == CW'(N));
            state   <= state_n;
        end
    end

    // Slot 0 sits in the most significant element position.
    always_comb begin
        arr_pack = '0;
        for (int i = 0; i < N; i++) arr_pack[(N-1-i)*W +: W] = mem[i];
    end

    assign bus.arr_out   = arr_pack;
    assign bus.count     = cnt;
    assign bus.empty     = empty_r;
    assign bus.full      = full_r;
    assign bus.out_valid = ov;
    assign bus.out_value = val;
    assign bus.out_idx   = oidx;
    assign bus.rem_err   = err;
    assign fsm_state     = state;
endmodule

// File: doc/indexed_lsh_buf.md
INDEXED_LSH_BUF -- requirements
Module: indexed_lsh_buf

Interface
REQ-001 SHALL have parameter data_width_param, default 32, element width in bits.
REQ-002 SHALL have parameter max_elements_param, default 16, number of element slots.
REQ-003 SHALL have parameter idx_width_param, default 4, index width.
REQ-004 SHALL use one clock and an asynchronous active-low reset.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 load_valid  input  1  request to replace the whole array.
REQ-008 load_arr  input  512  new array; element 0 in bits 511:480, element 15 in bits 31:0.
REQ-009 load_count  input  5  number of valid elements in load_arr (0..16).
REQ-010 load_ready  output  1  load accepted when load_valid && load_ready.
REQ-011 rem_valid  input  1  request to remove one element.
REQ-012 rem_idx  input  4  slot of the element to remove.
REQ-013 rem_ready  output  1  removal accepted when rem_valid && rem_ready.
REQ-014 out_valid  output  1  out_value/out_idx hold a removed element.
REQ-015 out_ready  input  1  consumer accepts the output when out_valid && out_ready.
REQ-016 out_value  output  32  removed element value.
REQ-017 out_idx  output  4  slot from which out_value was removed.
REQ-018 arr_out  output  512  current array contents, same packing as load_arr.
REQ-019 count  output  5  number of valid elements.
REQ-020 empty, full  output  1 each  count==0 / count==16.
REQ-021 rem_err  output  1  one-cycle pulse on an accepted out-of-range removal.

Function
REQ-022 The block is the inverse of the indexed right-shift insert: an accepted removal at idx k with k<count SHALL set element j to old element j+1 for k<=j<=count-2, zero element count-1, leave elements <k unchanged, and decrement count, all in the edge that accepts the request.
REQ-023 The same edge SHALL register out_value=old element k, out_idx=k and set out_valid; latency from acceptance to out_valid is 1 cycle.
REQ-024 out_valid SHALL stay high with stable out_value/out_idx until out_ready is sampled high; it then clears unless a new removal is accepted in the same cycle, in which case the new value is loaded (back-to-back, 1 removal per cycle).
REQ-025 rem_ready SHALL equal !empty && !load_valid && (!out_valid || out_ready).
REQ-026 load_ready SHALL equal !out_valid || out_ready; load takes priority over removal when both are valid.
REQ-027 An accepted load SHALL write load_arr, set count=min(load_count,16), and zero all slots >= count; out_valid is unaffected by a load except as in REQ-024.
REQ-028 An accepted removal with rem_idx >= count SHALL leave array and count unchanged, not set out_valid, and pulse rem_err for one cycle.
REQ-029 Removal at k=count-1 SHALL only zero that slot; removal at k=0 with count=16 SHALL shift all 15 remaining elements and clear slot 15.
REQ-030 The control FSM SHALL have states IDLE (count==0, out_valid low), ACTIVE (count>0, output free), STALL (out_valid high, out_ready low); rem_ready is low in IDLE and STALL.
REQ-031 Transitions: IDLE->ACTIVE on load with load_count>0; ACTIVE->STALL on accepted removal while out_ready low next cycle; STALL->ACTIVE/IDLE on out_ready according to count.
REQ-032 count, empty, full, arr_out SHALL be registered, never combinationally dependent on inputs.

Reset
REQ-033 While rst_n is low: arr_out=0, count=0, empty=1, full=0, out_valid=0, out_value=0, out_idx=0, rem_err=0, FSM in IDLE.
REQ-034 Reset asserted mid-operation SHALL discard any pending output and array contents immediately; the first edge after release SHALL behave as from IDLE.

Verification
REQ-035 Load elements 10..25 in slots 0..15, count=16; remove idx 3 -> out_value=13, out_idx=3, slots 3..14 = 14..25, slot 15 = 0, count=15.
REQ-036 Count=16, out_ready held high, rem_idx=0 valid for 16 cycles -> out_value 10,11,..,25 on consecutive cycles, then empty=1, rem_ready=0.
REQ-037 out_ready low for 3 cycles after a removal -> out_valid held, out_value stable, rem_ready=0, array unchanged until out_ready=1.
REQ-038 count=4, remove idx 9 -> rem_err pulses once, count stays 4, out_valid stays 0.
REQ-039 load_valid and rem_valid together -> load applied, no removal, rem_ready=0 that cycle.
REQ-040 Assert rst_n low while out_valid=1 and count=7 -> all outputs zero, empty=1 asynchronously.
